// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file constants and the write-request record used by the
// writeback sources that feed the register file write port.
package regfile_write_arbiter_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_ZERO   = 0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] idx;
    logic [REG_DATA_W-1:0] data;
  } wr_req_t;

  function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] idx);
    return idx == REG_ADDR_W'(REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Valid/ready request bundle between the writeback sources (master) and the
// write-port arbiter (slave); requester i occupies slice i of each vector.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_reg;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (
    output req_valid,
    output req_reg,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_reg,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the requester just after last_grant has
// highest priority, last_grant itself the lowest.
module regfile_write_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 3,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic found;
  int   cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (en_i && !found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_REQ
// writeback sources, with a one-cycle registered output stage.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  regfile_write_arbiter_if.slave     req,
  input  logic                       hold,
  output logic                       RegWrite,
  output logic [ADDR_W-1:0]          WriteReg,
  output logic [DATA_W-1:0]          WriteD,
  output logic [$clog2(NUM_REQ)-1:0] last_grant
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               arb_en;
  logic               xfer;
  logic [ADDR_W-1:0]  sel_reg;
  logic [DATA_W-1:0]  sel_data;

  logic               regwrite_d, regwrite_q;
  logic [ADDR_W-1:0]  writereg_d, writereg_q;
  logic [DATA_W-1:0]  writed_d,   writed_q;
  logic [IDX_W-1:0]   last_d,     last_q;

  // No grants while in reset so a source never sees its request consumed then.
  assign arb_en = !hold && !rst;

  regfile_write_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i        (req.req_valid),
    .last_grant_i (last_q),
    .en_i         (arb_en),
    .gnt_o        (gnt),
    .idx_o        (gnt_idx)
  );

  assign req.req_ready = gnt;
  assign xfer          = |(gnt & req.req_valid);
  assign sel_reg       = req.req_reg[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign sel_data      = req.req_data[int'(gnt_idx)*DATA_W +: DATA_W];

  always_comb begin
    regwrite_d = 1'b0;
    writereg_d = writereg_q;
    writed_d   = writed_q;
    last_d     = last_q;
    if (xfer) begin
      // r0 writes are consumed but suppressed so r0 reads zero regardless of the file.
      regwrite_d = (ADDR_W != REG_ADDR_W) ? (sel_reg != '0)
                                          : !is_zero_reg(REG_ADDR_W'(sel_reg));
      writereg_d = sel_reg;
      writed_d   = sel_data;
      last_d     = gnt_idx;
    end
  end

  // Output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      writereg_q <= '0;
      writed_q   <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
    end else begin
      regwrite_q <= regwrite_d;
      writereg_q <= writereg_d;
      writed_q   <= writed_d;
      last_q     <= last_d;
    end
  end

  assign RegWrite   = regwrite_q;
  assign WriteReg   = writereg_q;
  assign WriteD     = writed_q;
  assign last_grant = last_q;

endmodule
